// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and the line/frame total helper.
package vga_pkg;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;
   localparam int unsigned CNT_W_DEF    = 10;
   localparam int unsigned COLOR_W_DEF  = 8;

   function automatic int unsigned timing_total(input int unsigned active,
                                                input int unsigned fp,
                                                input int unsigned sync,
                                                input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bus between the timing generator (master) and the renderer/display side (slave).
interface vga_timing_gen_if import vga_pkg::*; #(
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned COLOR_W = COLOR_W_DEF
) ();

   logic               vga_clk;
   logic [COLOR_W-1:0] pix_red;
   logic [COLOR_W-1:0] pix_green;
   logic [COLOR_W-1:0] pix_blue;
   logic [CNT_W-1:0]   x;
   logic [CNT_W-1:0]   y;
   logic               coord_active;
   logic               hor_sync;
   logic               ver_sync;
   logic               de;
   logic [COLOR_W-1:0] red;
   logic [COLOR_W-1:0] green;
   logic [COLOR_W-1:0] blue;
   logic               line_start;
   logic               frame_start;

   modport master (
      input  vga_clk, pix_red, pix_green, pix_blue,
      output x, y, coord_active, hor_sync, ver_sync, de,
             red, green, blue, line_start, frame_start
   );

   modport slave (
      output vga_clk, pix_red, pix_green, pix_blue,
      input  x, y, coord_active, hor_sync, ver_sync, de,
             red, green, blue, line_start, frame_start
   );

endinterface

// File: rtl/vga_delay_line.sv
// Enable-gated shift register used to re-align coordinate-stage flags with renderer latency.
module vga_delay_line import vga_pkg::*; #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] rst_val,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   if (DEPTH == 0) begin : g_wire
      logic unused_ok;
      assign unused_ok = ^{clk, rst, en, rst_val};
      assign dout      = din;
   end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
         stage_d = stage_q;
         if (en) begin
            stage_d[0] = din;
            for (int i = 1; i < int'(DEPTH); i++) begin
               stage_d[i] = stage_q[i-1];
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
               stage_q[i] <= rst_val;
            end
         end else begin
            stage_q <= stage_d;
         end
      end

      assign dout = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster counter, sync decode and renderer-aligned pixel output stage.
module vga_timing_gen import vga_pkg::*; #(
   parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
   parameter int unsigned H_FP       = H_FP_DEF,
   parameter int unsigned H_SYNC     = H_SYNC_DEF,
   parameter int unsigned H_BP       = H_BP_DEF,
   parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
   parameter int unsigned V_FP       = V_FP_DEF,
   parameter int unsigned V_SYNC     = V_SYNC_DEF,
   parameter int unsigned V_BP       = V_BP_DEF,
   parameter bit          HSYNC_POL  = 1'b0,
   parameter bit          VSYNC_POL  = 1'b0,
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter int unsigned COLOR_W    = COLOR_W_DEF,
   parameter int unsigned PIPE_DELAY = 0
) (
   input  logic             clk,
   input  logic             rst,
   vga_timing_gen_if.master bus
);

   localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] HA_END   = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] VA_END   = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   if (H_TOTAL > (2 ** CNT_W)) begin : g_bad_h_total
      $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
   end
   if (V_TOTAL > (2 ** CNT_W)) begin : g_bad_v_total
      $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
   end
   if (PIPE_DELAY > 15) begin : g_bad_pipe
      $error("vga_timing_gen: PIPE_DELAY must be 0..15");
   end

   logic                tick;
   logic [CNT_W-1:0]    x_q, x_d;
   logic [CNT_W-1:0]    y_q, y_d;
   logic                line_start_q, line_start_d;
   logic                frame_start_q, frame_start_d;
   logic                coord_active;
   logic                hs_raw;
   logic                vs_raw;
   logic [2:0]          flags_dly;
   logic                de_q, de_d;
   logic                hor_sync_q, hor_sync_d;
   logic                ver_sync_q, ver_sync_d;
   logic [COLOR_W-1:0]  red_q, red_d;
   logic [COLOR_W-1:0]  green_q, green_d;
   logic [COLOR_W-1:0]  blue_q, blue_d;

   assign tick = bus.vga_clk;

   // Strobes default low so they last one clk even if the next edge is stalled.
   always_comb begin
      x_d           = x_q;
      y_d           = y_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (tick) begin
         if (x_q == H_LAST) begin
            x_d          = '0;
            line_start_d = 1'b1;
            if (y_q == V_LAST) begin
               y_d           = '0;
               frame_start_d = 1'b1;
            end else begin
               y_d = y_q + CNT_W'(1);
            end
         end else begin
            x_d = x_q + CNT_W'(1);
         end
      end
   end

   assign coord_active = (x_q < HA_END) && (y_q < VA_END);
   assign hs_raw       = (x_q >= HS_START) && (x_q < HS_END);
   assign vs_raw       = (y_q >= VS_START) && (y_q < VS_END);

   vga_delay_line #(
      .WIDTH (3),
      .DEPTH (PIPE_DELAY)
   ) u_flag_dly (
      .clk     (clk),
      .rst     (rst),
      .en      (tick),
      .rst_val (3'b000),
      .din     ({coord_active, hs_raw, vs_raw}),
      .dout    (flags_dly)
   );

   always_comb begin
      de_d       = de_q;
      hor_sync_d = hor_sync_q;
      ver_sync_d = ver_sync_q;
      red_d      = red_q;
      green_d    = green_q;
      blue_d     = blue_q;
      if (tick) begin
         de_d       = flags_dly[2];
         hor_sync_d = flags_dly[1] ? HSYNC_POL : ~HSYNC_POL;
         ver_sync_d = flags_dly[0] ? VSYNC_POL : ~VSYNC_POL;
         red_d      = flags_dly[2] ? bus.pix_red   : '0;
         green_d    = flags_dly[2] ? bus.pix_green : '0;
         blue_d     = flags_dly[2] ? bus.pix_blue  : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         de_q          <= 1'b0;
         hor_sync_q    <= ~HSYNC_POL;
         ver_sync_q    <= ~VSYNC_POL;
         red_q         <= '0;
         green_q       <= '0;
         blue_q        <= '0;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         de_q          <= de_d;
         hor_sync_q    <= hor_sync_d;
         ver_sync_q    <= ver_sync_d;
         red_q         <= red_d;
         green_q       <= green_d;
         blue_q        <= blue_d;
      end
   end

   assign bus.x            = x_q;
   assign bus.y            = y_q;
   assign bus.coord_active = coord_active;
   assign bus.hor_sync     = hor_sync_q;
   assign bus.ver_sync     = ver_sync_q;
   assign bus.de           = de_q;
   assign bus.red          = red_q;
   assign bus.green        = green_q;
   assign bus.blue         = blue_q;
   assign bus.line_start   = line_start_q;
   assign bus.frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a tiny 8x6 raster with a 2-tick renderer and the default 640x480 raster,
// both compared every clk against a tick-count reference model.
module tb_vga_timing_gen;
   import vga_pkg::*;

   typedef struct {
      int ha, hfp, hs, hbp;
      int va, vfp, vs, vbp;
      bit hp, vp;
      int d;
   } cfg_t;

   typedef struct {
      int x, y, act, hsync, vsync, de, r, g, b, ls, fs;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic vga_en = 1'b0;

   int t      = 0;
   bit le     = 1'b0;
   int errors = 0;
   int checks = 0;

   cfg_t cfg_a = '{ha:4, hfp:1, hs:2, hbp:1, va:3, vfp:1, vs:1, vbp:1, hp:1'b1, vp:1'b1, d:2};
   cfg_t cfg_b = '{ha:640, hfp:16, hs:96, hbp:48, va:480, vfp:10, vs:2, vbp:33, hp:1'b0, vp:1'b0, d:0};

   always #5 clk = ~clk;

   vga_timing_gen_if #(.CNT_W(10), .COLOR_W(8)) bus_a ();
   vga_timing_gen_if #(.CNT_W(10), .COLOR_W(8)) bus_b ();

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
      .CNT_W(10), .COLOR_W(8), .PIPE_DELAY(2)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   vga_timing_gen #(
      .CNT_W(10), .COLOR_W(8), .PIPE_DELAY(0)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   // Renderer for dut_a: two enabled-tick register stages on the issued coordinate.
   logic [9:0] rx0 = '0, ry0 = '0, rx1 = '0, ry1 = '0;
   always @(posedge clk) begin
      if (vga_en) begin
         rx0 <= bus_a.x;
         ry0 <= bus_a.y;
         rx1 <= rx0;
         ry1 <= ry0;
      end
   end

   assign bus_a.vga_clk   = vga_en;
   assign bus_a.pix_red   = rx1[7:0];
   assign bus_a.pix_green = ry1[7:0];
   assign bus_a.pix_blue  = 8'(rx1 + ry1);

   assign bus_b.vga_clk   = vga_en;
   assign bus_b.pix_red   = bus_b.x[7:0];
   assign bus_b.pix_green = bus_b.y[7:0];
   assign bus_b.pix_blue  = 8'(bus_b.x + bus_b.y);

   // After t enabled ticks since reset the raster sits at tick t; the output register
   // holds the coordinate of tick t-1-d.
   function automatic exp_t model(input cfg_t c, input int tt, input bit last_en);
      exp_t e;
      int ht, vt, k, px, py;
      ht = c.ha + c.hfp + c.hs + c.hbp;
      vt = c.va + c.vfp + c.vs + c.vbp;
      k  = tt - 1 - c.d;
      e.x     = tt % ht;
      e.y     = (tt / ht) % vt;
      e.act   = int'(e.x < c.ha && e.y < c.va);
      e.ls    = int'(last_en && e.x == 0);
      e.fs    = int'(last_en && e.x == 0 && e.y == 0);
      e.de    = 0;
      e.hsync = int'(!c.hp);
      e.vsync = int'(!c.vp);
      e.r     = 0;
      e.g     = 0;
      e.b     = 0;
      if (k >= 0) begin
         px = k % ht;
         py = (k / ht) % vt;
         if (px >= c.ha + c.hfp && px < c.ha + c.hfp + c.hs) e.hsync = int'(c.hp);
         if (py >= c.va + c.vfp && py < c.va + c.vfp + c.vs) e.vsync = int'(c.vp);
         if (px < c.ha && py < c.va) begin
            e.de = 1;
            e.r  = px % 256;
            e.g  = py % 256;
            e.b  = (px + py) % 256;
         end
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d (t=%0d)", tag, obs, expv, t);
      end
   endtask

   task automatic check_all();
      exp_t ea, eb;
      ea = model(cfg_a, t, le);
      eb = model(cfg_b, t, le);
      chk("a.x",            32'(bus_a.x),            ea.x);
      chk("a.y",            32'(bus_a.y),            ea.y);
      chk("a.coord_active", 32'(bus_a.coord_active), ea.act);
      chk("a.hor_sync",     32'(bus_a.hor_sync),     ea.hsync);
      chk("a.ver_sync",     32'(bus_a.ver_sync),     ea.vsync);
      chk("a.de",           32'(bus_a.de),           ea.de);
      chk("a.red",          32'(bus_a.red),          ea.r);
      chk("a.green",        32'(bus_a.green),        ea.g);
      chk("a.blue",         32'(bus_a.blue),         ea.b);
      chk("a.line_start",   32'(bus_a.line_start),   ea.ls);
      chk("a.frame_start",  32'(bus_a.frame_start),  ea.fs);
      chk("b.x",            32'(bus_b.x),            eb.x);
      chk("b.y",            32'(bus_b.y),            eb.y);
      chk("b.coord_active", 32'(bus_b.coord_active), eb.act);
      chk("b.hor_sync",     32'(bus_b.hor_sync),     eb.hsync);
      chk("b.ver_sync",     32'(bus_b.ver_sync),     eb.vsync);
      chk("b.de",           32'(bus_b.de),           eb.de);
      chk("b.red",          32'(bus_b.red),          eb.r);
      chk("b.green",        32'(bus_b.green),        eb.g);
      chk("b.blue",         32'(bus_b.blue),         eb.b);
      chk("b.line_start",   32'(bus_b.line_start),   eb.ls);
      chk("b.frame_start",  32'(bus_b.frame_start),  eb.fs);
   endtask

   task automatic cyc(input bit r, input bit e);
      rst    = r;
      vga_en = e;
      @(posedge clk);
      if (r) begin
         t  = 0;
         le = 1'b0;
      end else if (e) begin
         t++;
         le = 1'b1;
      end else begin
         le = 1'b0;
      end
      @(negedge clk);
      check_all();
   endtask

   initial begin
      @(negedge clk);

      // reset with tick enabled, then with tick stalled
      cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b0);

      // free-running: many 8x6 frames, wraps and strobes
      repeat (300) cyc(1'b0, 1'b1);

      // 1-in-2 enable: periods double, stalled cycles hold state
      for (int i = 0; i < 200; i++) cyc(1'b0, (i % 2) == 0);

      // random enable pattern
      repeat (1500) cyc(1'b0, $urandom_range(0, 3) != 0);

      // mid-frame reset while enabled, random run, then reset while stalled
      cyc(1'b1, 1'b1);
      repeat (150) cyc(1'b0, $urandom_range(0, 1) == 1);
      cyc(1'b1, 1'b0);

      // long enabled run: default raster crosses several line boundaries
      repeat (2600) cyc(1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
